tick_scheduler: RTL
===================

// Module: tick_scheduler
// PURPOSE
//  Shares one divided clock-enable pulse (tick_in, from the clock divider) among NUM_CH
//  independent timing channels. Each channel counts base ticks and emits a one-cycle
//  ch_tick after a programmable number of them, either periodically or once.
//  Sits between the clock divider and game-timing consumers (debounce, LED scan, round timer).
//  Configured through a valid/ready port; started and stopped by per-channel strobes.
// PARAMETERS
//  NUM_CH          4   number of channels (>=1)
//  PW              8   period/counter width; max period 2^PW-1 base ticks
//  DEFAULT_PERIOD  1   period loaded into every channel at reset (1..2^PW-1)
// PORTS
//  clk_in       in   1                      system clock
//  reset        in   1                      asynchronous, active-high reset
//  tick_in      in   1                      base clock-enable, one-cycle pulse
//  cfg_valid    in   1                      config request
//  cfg_ready    out  1                      config accept; transfer when valid&&ready
//  cfg_ch       in   CW=max(1,$clog2(NUM_CH)) target channel
//  cfg_period   in   PW                     new period in base ticks
//  cfg_oneshot  in   1                      1 = one-shot, 0 = periodic
//  cfg_err      out  1                      one-cycle pulse: accepted request was rejected
//  start        in   NUM_CH                 per-channel start/restart strobe
//  stop         in   NUM_CH                 per-channel stop strobe
//  ch_tick      out  NUM_CH                 per-channel one-cycle expiry pulse (registered)
//  ch_active    out  NUM_CH                 channel in RUN (direct state-register output)
// BEHAVIOUR
//  - Reset (async, immediate): all channels IDLE, count=0, period=DEFAULT_PERIOD, oneshot=0;
//    ch_tick=0, ch_active=0, cfg_err=0, cfg_ready=1. Reset mid-run clears pulses at once.
//  - Per-channel FSM, states IDLE/RUN. Priority per channel per cycle: stop > start > tick_in.
//    stop[i]:  ->IDLE, count<=0 (also when already IDLE).
//    start[i]: ->RUN, count<=0 (restart when already RUN); a tick_in in the same cycle is ignored.
//    RUN & tick_in: if count >= period-1 then count<=0, ch_tick[i]<=1 next cycle,
//      and ->IDLE when oneshot; else count<=count+1.
//    Terminal tick with stop in the same cycle: no pulse.
//  - Latency: ch_tick[i] is high the cycle after the Pth tick_in following start, for one cycle.
//    In one-shot mode ch_active[i] falls in that same cycle. With period=1, pulses follow every tick_in.
//  - Config handshake: cfg_ready is registered. It is 1 except for the single cycle after an accept,
//    which gives at most one transfer per 2 cycles. cfg_valid may be held; data is sampled only on accept.
//  - Rejects: an accepted request with cfg_period==0 or cfg_ch>=NUM_CH leaves all state unchanged.
//    cfg_err pulses the cycle after the accept. A valid request updates period/oneshot on accept.
//  - Config on a running channel: count is not touched, and the tick_in in the accept cycle uses the old
//    period. The new period takes effect from the next cycle. If count >= new period-1, the next tick_in fires.
//    The new oneshot flag governs the next terminal tick.
//  - Counter arithmetic is PW-bit unsigned; count never exceeds 2^PW-2, so there is no wrap.
//  - Channels are fully independent; a simultaneous terminal tick on several channels pulses all of them.
// TESTING
//  1 Hold reset high, assert it mid-run while ch_active=4'b0001 -> ch_tick=0 and ch_active=0 with no
//    clock edge; cfg_ready=1 after release.
//  2 Program ch0 period=3 periodic, start[0], tick_in every 4 clk -> ch_tick[0] high one cycle after
//    the 3rd, 6th and 9th tick_in only.
//  3 Program ch1 period=2 oneshot, start[1] -> one pulse after the 2nd tick_in, ch_active[1]=0 in the
//    pulse cycle, no pulse after the 4th tick_in.
//  4 NUM_CH=3: cfg_ch=3 and cfg_period=0 requests -> both accepted, cfg_err pulses once each, periods
//    unchanged; cfg_ready=0 the cycle after each accept.
//  5 start[2]&stop[2] in the same cycle -> ch_active[2]=0. Stop on a terminal tick -> no ch_tick[2].
//    Start on a tick_in cycle -> count=0.
//  6 ch0 running period=10 at count=5, reconfigure to period=2 -> ch_tick[0] after the next tick_in,
//    then every 2 tick_in.

Source files
------------

// File: rtl/tick_scheduler_if.sv
// Configuration port of the tick scheduler: one request carries a channel
// number, a period in base ticks and a one-shot flag.
//
// Handshake: the master raises cfg_valid and holds cfg_ch/cfg_period/
// cfg_oneshot stable until it sees cfg_valid && cfg_ready at a rising edge.
// That edge is the transfer, and the data is sampled only then. The slave
// may drop cfg_ready at any time. cfg_err is a one-cycle pulse from the
// slave in the cycle after a transfer whose request was refused.
interface tick_scheduler_if #(
   parameter int NUM_CH = 4,
   parameter int PW     = 8
);
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic          cfg_valid;
   logic          cfg_ready;
   logic [CW-1:0] cfg_ch;
   logic [PW-1:0] cfg_period;
   logic          cfg_oneshot;
   logic          cfg_err;

   modport master (
      output cfg_valid, cfg_ch, cfg_period, cfg_oneshot,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_period, cfg_oneshot,
      output cfg_ready, cfg_err
   );
endinterface

// File: rtl/tick_scheduler.sv
// Tick scheduler: several independent timing channels share one divided
// clock-enable pulse. Each channel counts base ticks and emits a one-cycle
// ch_tick after a programmable number of them, periodically or once.
module tick_scheduler #(
   parameter int NUM_CH         = 4,
   parameter int PW             = 8,
   parameter int DEFAULT_PERIOD = 1
) (
   input  logic                clk_in,
   input  logic                reset,
   input  logic                tick_in,
   tick_scheduler_if.slave     cfg,
   input  logic [NUM_CH-1:0]   start,
   input  logic [NUM_CH-1:0]   stop,
   output logic [NUM_CH-1:0]   ch_tick,
   output logic [NUM_CH-1:0]   ch_active
);

   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CW:0] NUM_CH_W = (CW+1)'(NUM_CH);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        state   [NUM_CH];
   logic [PW-1:0] count   [NUM_CH];
   logic [PW-1:0] period  [NUM_CH];
   logic          oneshot [NUM_CH];

   logic              accept;
   logic              bad_req;
   logic [CW:0]       ch_ext;
   logic [NUM_CH-1:0] cfg_hit;

   assign accept  = cfg.cfg_valid && cfg.cfg_ready;
   assign ch_ext  = {1'b0, cfg.cfg_ch};
   // A zero period would never expire and an unknown channel has no state to update.
   assign bad_req = (cfg.cfg_period == '0) || (ch_ext >= NUM_CH_W);

   // Decode which channel (if any) takes the accepted configuration.
   always_comb begin
      cfg_hit = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cfg_hit[i] = accept && !bad_req && (cfg.cfg_ch == CW'(i));
      end
   end

   // Activity is read straight off the state register so it drops in the pulse cycle.
   always_comb begin
      ch_active = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_active[i] = (state[i] == RUN);
      end
   end

   // Per-channel FSM: stop beats start beats tick_in; config lands after this cycle's tick.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state[i]   <= IDLE;
            count[i]   <= '0;
            period[i]  <= PW'(DEFAULT_PERIOD);
            oneshot[i] <= 1'b0;
         end
         ch_tick <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            ch_tick[i] <= 1'b0;
            if (stop[i]) begin
               state[i] <= IDLE;
               count[i] <= '0;
            end else if (start[i]) begin
               // Restart discards any tick_in arriving in the same cycle.
               state[i] <= RUN;
               count[i] <= '0;
            end else if ((state[i] == RUN) && tick_in) begin
               // ">=" lets a shortened period fire on the very next tick.
               if (count[i] >= (period[i] - 1'b1)) begin
                  count[i]   <= '0;
                  ch_tick[i] <= 1'b1;
                  if (oneshot[i]) begin
                     state[i] <= IDLE;
                  end
               end else begin
                  count[i] <= count[i] + 1'b1;
               end
            end
            if (cfg_hit[i]) begin
               period[i]  <= cfg.cfg_period;
               oneshot[i] <= cfg.cfg_oneshot;
            end
         end
      end
   end

   // Config port: ready drops for one cycle after each transfer, error flags a refused one.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         cfg.cfg_ready <= 1'b1;
         cfg.cfg_err   <= 1'b0;
      end else begin
         cfg.cfg_ready <= !accept;
         cfg.cfg_err   <= accept && bad_req;
      end
   end

endmodule
